// File: rtl/ram_master_pkg.sv
// Shared types and default widths for the single-port sync RAM bus initiator.
package ram_master_pkg;

   localparam int DEF_ADDR_WIDTH   = 16;
   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_LEN_WIDTH    = 4;
   localparam int DEF_READ_LATENCY = 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      RD_ISSUE = 2'd2,
      RD_WAIT  = 2'd3
   } state_e;

endpackage

// File: rtl/ram_master_addr_gen.sv
// Loadable RAM address counter with a beats-remaining down-counter and last-beat flag.
module ram_master_addr_gen #(
   parameter int AW = 16,
   parameter int LW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          advance,
   input  logic [AW-1:0] load_addr,
   input  logic [LW-1:0] load_len,
   output logic [AW-1:0] addr,
   output logic          last
);

   logic [AW-1:0] addr_q, addr_d;
   logic [LW-1:0] left_q, left_d;

   // Next address / remaining-beat count; the address wraps naturally at 2^AW.
   always_comb begin
      addr_d = addr_q;
      left_d = left_q;
      if (load) begin
         addr_d = load_addr;
         left_d = load_len;
      end else if (advance) begin
         addr_d = addr_q + AW'(1);
         left_d = left_q - LW'(1);
      end else begin
         addr_d = addr_q;
         left_d = left_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         left_q <= '0;
      end else begin
         addr_q <= addr_d;
         left_q <= left_d;
      end
   end

   assign addr = addr_q;
   assign last = (left_q == '0);

endmodule

// File: rtl/ram_bus_master.sv
// Burst initiator for the single-port synchronous RAM bus (addr, tristate data, cs/we/oe).
// Optional request range check is enabled by defining RAM_MASTER_RANGE_CHECK_EN.
module ram_bus_master
   import ram_master_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
   parameter int READ_LATENCY = DEF_READ_LATENCY,
   parameter int MEM_DEPTH    = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_last,
   output logic                  busy,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   inout  wire  [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe
);

`ifdef RAM_MASTER_RANGE_CHECK_EN
   localparam logic RANGE_CHECK = 1'b1;
`else
   localparam logic RANGE_CHECK = 1'b0;
`endif
   localparam int AW1 = ADDR_WIDTH + 1;
   localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   state_e                 state_q, state_d;
   logic [WCW-1:0]         wait_q, wait_d;
   logic                   rsp_valid_q, rsp_last_q, err_q, err_d;
   logic [DATA_WIDTH-1:0]  rsp_data_q;
   logic                   ag_load, ag_adv, ag_last, capture, range_bad;
   logic [AW1-1:0]         end_addr;

   // One extra bit so a burst running past the top of memory is visible rather than wrapping.
   assign end_addr  = {1'b0, req_addr} + AW1'(req_len);
   assign range_bad = RANGE_CHECK && (end_addr >= AW1'(MEM_DEPTH));

   ram_master_addr_gen #(
      .AW (ADDR_WIDTH),
      .LW (LEN_WIDTH)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .load      (ag_load),
      .advance   (ag_adv),
      .load_addr (req_addr),
      .load_len  (req_len),
      .addr      (mem_addr),
      .last      (ag_last)
   );

   // Next-state and bus strobes; write strobes follow wdata_valid in the same cycle.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      ag_load     = 1'b0;
      ag_adv      = 1'b0;
      capture     = 1'b0;
      err_d       = 1'b0;
      req_ready   = 1'b0;
      wdata_ready = 1'b0;
      mem_cs      = 1'b0;
      mem_we      = 1'b0;
      mem_oe      = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = ~rst;
            if (req_valid && !rst) begin
               if (range_bad) begin
                  err_d = 1'b1;
               end else begin
                  ag_load = 1'b1;
                  state_d = req_write ? WRITE : RD_ISSUE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            if (wdata_valid) begin
               mem_cs      = 1'b1;
               mem_we      = 1'b1;
               wdata_ready = 1'b1;
               if (ag_last) begin
                  state_d = IDLE;
               end else begin
                  ag_adv = 1'b1;
               end
            end else begin
               state_d = WRITE;
            end
         end
         RD_ISSUE: begin
            mem_cs  = 1'b1;
            mem_oe  = 1'b1;
            wait_d  = '0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            mem_cs = 1'b1;
            mem_oe = 1'b1;
            if (wait_q == WCW'(READ_LATENCY - 1)) begin
               capture = 1'b1;
               if (ag_last) begin
                  state_d = IDLE;
               end else begin
                  ag_adv  = 1'b1;
                  state_d = RD_ISSUE;
               end
            end else begin
               wait_d = wait_q + WCW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, wait counter and registered response/error outputs; reset drops any beat in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         rsp_valid_q <= capture;
         rsp_last_q  <= capture & ag_last;
         err_q       <= err_d;
         if (capture) begin
            rsp_data_q <= mem_data;
         end
      end
   end

   assign mem_data  = (mem_cs && mem_we) ? wdata : {DATA_WIDTH{1'bz}};
   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_last  = rsp_last_q;
   assign rsp_data  = rsp_data_q;
   assign err       = err_q;

endmodule
